// File: rtl/instr_dispatcher.sv
// rtl/instr_dispatcher.sv - hazard-aware instruction dispatcher into per-core FIFOs
module instr_dispatcher #(
  parameter int NUM_CORES = 2,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 11
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [NUM_CORES-1:0]          out_valid,
  output logic [NUM_CORES*DATA_W-1:0]   out_data,
  input  logic [NUM_CORES-1:0]          out_ready,
  output logic                          hazard_stall,
  output logic [15:0]                   stall_count
);

  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {RUN, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      mem_q    [NUM_CORES][DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q [NUM_CORES];
  logic [PTR_W-1:0]       wr_ptr_q [NUM_CORES];
  logic [CNT_W-1:0]       count_q  [NUM_CORES];
  logic [CORE_W-1:0]      rr_ptr_q;
  logic [15:0]            stall_cnt_q;

  logic                   in_force;
  logic [CORE_W-1:0]      in_fcore;
  logic [NUM_CORES-1:0]   full, haz, push, pop;
  logic                   haz_any, haz_multi;
  logic [CORE_W-1:0]      haz_idx;
  logic [CORE_W-1:0]      tgt;
  logic                   tgt_ok;
  logic                   accept;

  assign in_force = in_data[27];
  assign in_fcore = in_data[26 -: CORE_W];

  // RAW/WAR/WAW between an incoming instruction a and a queued entry e;
  // a field only participates when its is_reg_n flag is low at both ends.
  function automatic logic conflict(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e);
    logic raw, war, waw;
    raw = !a[23] && !e[22] && (a[ADDR_W-1:0] == e[2*ADDR_W-1:ADDR_W]);
    war = !a[22] && !e[23] && (a[2*ADDR_W-1:ADDR_W] == e[ADDR_W-1:0]);
    waw = !a[22] && !e[22] && (a[2*ADDR_W-1:ADDR_W] == e[2*ADDR_W-1:ADDR_W]);
    return raw | war | waw;
  endfunction

  // A slot holds live data when its distance from the read pointer is below count.
  function automatic logic slot_live(input logic [PTR_W-1:0] slot, input logic [PTR_W-1:0] rd,
                                     input logic [CNT_W-1:0] cnt);
    logic [PTR_W-1:0] off;
    off = slot - rd;
    return {1'b0, off} < cnt;
  endfunction

  // Per-core full flags and hazard vector from registered FIFO contents.
  always_comb begin
    haz  = '0;
    full = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      full[c] = (count_q[c] == FULL_CNT);
      for (int s = 0; s < DEPTH; s++) begin
        if (slot_live(PTR_W'(s), rd_ptr_q[c], count_q[c]) && conflict(in_data, mem_q[c][s]))
          haz[c] = 1'b1;
      end
    end
  end

  // Reduce the hazard vector to any / more-than-one / index of the single hit.
  always_comb begin
    haz_any   = 1'b0;
    haz_multi = 1'b0;
    haz_idx   = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (haz[c]) begin
        if (haz_any) haz_multi = 1'b1;
        haz_any = 1'b1;
        haz_idx = CORE_W'(c);
      end
    end
  end

  // Target selection: forced core, then single-hazard affinity, then round-robin.
  always_comb begin
    tgt    = '0;
    tgt_ok = 1'b0;
    if (in_force) begin
      tgt    = in_fcore;
      tgt_ok = !full[in_fcore];
    end else if (haz_multi) begin
      tgt_ok = 1'b0;
    end else if (haz_any) begin
      tgt    = haz_idx;
      tgt_ok = !full[haz_idx];
    end else begin
      for (int k = 1; k <= NUM_CORES; k++) begin
        if (!tgt_ok && !full[rr_ptr_q + CORE_W'(k)]) begin
          tgt    = rr_ptr_q + CORE_W'(k);
          tgt_ok = 1'b1;
        end
      end
    end
  end

  assign in_ready     = (state_q == RUN) && tgt_ok;
  assign accept       = in_valid && in_ready;
  assign hazard_stall = (state_q == HOLD);
  assign stall_count  = stall_cnt_q;

  // Next-state: hold while two or more cores conflict with the offered instruction.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (in_valid && !in_force && haz_multi) state_d = HOLD;
      HOLD:    if (!in_valid || in_force || !haz_multi) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Per-core push/pop strobes and head outputs; empty FIFOs ignore out_ready.
  always_comb begin
    out_data = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      push[c]      = accept && (tgt == CORE_W'(c));
      pop[c]       = out_ready[c] && (count_q[c] != '0);
      out_valid[c] = (count_q[c] != '0);
      if (out_valid[c]) out_data[c*DATA_W +: DATA_W] = mem_q[c][rd_ptr_q[c]];
    end
  end

  // Control state: pointers, counts, round-robin pointer, FSM and stall counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      rr_ptr_q    <= CORE_W'(NUM_CORES - 1);
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else if (flush) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        rd_ptr_q[c] <= '0;
        wr_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      rr_ptr_q    <= CORE_W'(NUM_CORES - 1);
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
        if (pop[c])  rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   count_q[c] <= count_q[c] + 1'b1;
          2'b01:   count_q[c] <= count_q[c] - 1'b1;
          default: count_q[c] <= count_q[c];
        endcase
      end
      if (accept) rr_ptr_q <= tgt;
      state_q <= state_d;
      if (hazard_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // FIFO storage; contents need no reset because counts gate visibility.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++) begin
      if (push[c] && !flush) mem_q[c][wr_ptr_q[c]] <= in_data;
    end
  end

endmodule

// File: doc/instr_dispatcher.md
Name: instr_dispatcher

Overview:
- Parametrised, clocked successor to the two-core instruction arbiter.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and routes it into one of NUM_CORES per-core instruction FIFOs.
- Routing priority: forced-core field first, then register-hazard affinity (an instruction that conflicts with work queued for a core goes to that core), otherwise round-robin over non-full cores.
- Sits between fetch and the per-core pipelines; each core pops its FIFO with its own valid/ready.

Parameters:
- NUM_CORES, 2, number of core queues; must be 2, 4 or 8; CORE_W = log2(NUM_CORES).
- DEPTH, 8, entries per core FIFO; power of two, at least 2.
- DATA_W, 32, instruction width; at least 28.
- ADDR_W, 11, operand address width; src = instr[10:0], dst = instr[21:11].

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all queues and state.
- in_valid  input  1  instruction offered.
- in_data  input  DATA_W  instruction.
- in_ready  output  1  instruction accepted this cycle when in_valid and in_ready are both high.
- out_valid  output  NUM_CORES  per-core head valid.
- out_data  output  NUM_CORES*DATA_W  per-core head instruction; core c occupies bits [c*DATA_W +: DATA_W].
- out_ready  input  NUM_CORES  per-core pop.
- hazard_stall  output  1  current cycle is stalled on a multi-core hazard.
- stall_count  output  16  saturating count of hazard-stall cycles.

Behaviour:
- Clock and reset are decided: one clock clk; resetn asynchronous, active-low.
- Reset or flush:
  - All FIFOs empty, out_valid=0, out_data=0.
  - rr_ptr=NUM_CORES-1, so the first round-robin pick is core 0.
  - FSM=RUN, hazard_stall=0, stall_count=0.
  - flush has priority over push and pop in the same cycle.
- Instruction fields:
  - bit27 = force.
  - instr[26 -: CORE_W] = forced target core.
  - bit23 = src_is_reg_n. Src takes part in hazard checks only when bit23=0.
  - bit22 = dst_is_reg_n. Dst takes part in hazard checks only when bit22=0.
- Hazard check for core c:
  - Compare in_data against every VALID entry of FIFO c. Empty slots never match.
  - A match on any entry e is a hazard:
    - RAW: in src == e dst.
    - WAR: in dst == e src.
    - WAW: in dst == e dst.
  - Each compare uses the address plus its matching type bit (bit23 with a src field, bit22 with a dst field), and requires the flag at both ends to be 0.
  - The check runs on registered FIFO contents at the start of the cycle; a same-cycle pop is ignored, so the check is conservative.
- Target selection, in priority order:
  1. force=1: target is the forced core. If that core is full, stall.
  2. Exactly one core has a hazard: target is that core. If it is full, stall.
  3. Two or more cores have hazards: FSM goes to HOLD with hazard_stall=1. Stay there until the conflict set shrinks to at most one core, then return to RUN and evaluate the same instruction again.
  4. No hazard: target is the first non-full core scanning rr_ptr+1, rr_ptr+2, … (mod NUM_CORES). If all cores are full, stall.
- in_ready is high only when the FSM is in RUN and a target exists with count<DEPTH. It is computed from registered counts only; there is no combinational path from out_ready to in_ready.
- On accept:
  - Push to the target core.
  - rr_ptr <= target. This applies to every accepted instruction, including forced and hazard-routed ones.
- Latency:
  - An accepted instruction is visible on out_valid/out_data at the next rising edge.
  - FIFO order is preserved within each core.
- Per-core FIFO:
  - Simultaneous push and pop is legal, including at count=DEPTH-1.
  - A full FIFO never accepts a push; pop and push in the same cycle on a full FIFO still does not push.
  - An empty FIFO ignores out_ready.
  - Pointers wrap modulo DEPTH.
- stall_count increments each cycle hazard_stall=1 and saturates at 0xFFFF.
- in_data must be held stable while in_valid=1 and in_ready=0.

Test Plan:
1. Reset release, NUM_CORES=2, four independent instructions (bits 23/22=1), out_ready=0 -> cores get 0,1,0,1; out_valid=2'b11 one cycle after the first two accepts.
2. Instruction A (dst=0x005, bit22=0) goes to core 0; then B (src=0x005, bit23=0) arrives when round-robin would pick core 1 -> B goes to core 0 behind A (RAW affinity).
3. Force=1 with instr[26]=1 while core 1 is full -> in_ready=0. Pop core 1 -> accept on the following cycle; core 0 is untouched.
4. Core 0 holds dst 0x010 and core 1 holds dst 0x020; offer src=0x010, dst=0x020 -> hazard_stall=1 and stall_count increments each cycle. Drain core 1 -> RUN, instruction goes to core 0; stall_count stops.
5. DEPTH=8, all FIFOs full, then pop core 1 in the same cycle as an offered independent instruction -> no push that cycle; the push lands in core 1 next cycle.
6. Assert resetn low mid-stream, then flush in a later run -> out_valid=0 and stall_count=0 immediately; the first post-reset round-robin pick is core 0.
